// File: rtl/vga_scan_ctrl.sv
// VGA scan sequencer: pixel/line counters, active-low syncs, visible flag, frame strobe, vblank update handshake.
// Latency: all outputs registered; syncs/visible decoded from next counter value, so zero skew vs x_val/y_val.
// Backpressure: en=0 freezes the scan (counters, syncs, visible, update_req hold); ack still closes the window.
module vga_scan_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] x_val,
  output logic [9:0] y_val,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       frame_start,
  output logic       update_req,
  input  logic       update_ack,
  output logic [7:0] miss_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
  localparam logic [9:0] V_REQ_PRE = 10'(V_VISIBLE - 1);
  localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       wrap;
  logic       enter_req;
  logic [0:0] state;
  logic [0:0] state_next;
  logic [7:0] miss_next;

  // Next scan position; flags the frame wrap and the step onto the first blanking line.
  always_comb begin
    x_next    = x_val;
    y_next    = y_val;
    wrap      = 1'b0;
    enter_req = 1'b0;
    if (en) begin
      if (x_val == H_LAST) begin
        x_next = '0;
        if (y_val == V_LAST) begin
          y_next = '0;
          wrap   = 1'b1;
        end else begin
          y_next = y_val + 10'd1;
        end
        if (y_val == V_REQ_PRE) begin
          enter_req = 1'b1;
        end
      end else begin
        x_next = x_val + 10'd1;
      end
    end
  end

  // Update window: opens entering vertical blanking, closes on ack (wins over wrap) or on wrap as a miss.
  always_comb begin
    state_next = state;
    miss_next  = miss_count;
    case (state)
      ST_IDLE: begin
        if (enter_req) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (update_ack) begin
          state_next = ST_IDLE;
        end else if (wrap) begin
          state_next = ST_IDLE;
          if (miss_count != 8'hFF) begin
            miss_next = miss_count + 8'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Register counters and decode syncs/visible from the next position so they line up with x_val/y_val.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_val       <= '0;
      y_val       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      visible     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      x_val       <= x_next;
      y_val       <= y_next;
      hsync       <= !((x_next >= HS_START) && (x_next < HS_END));
      vsync       <= !((y_next >= VS_START) && (y_next < VS_END));
      visible     <= (x_next < H_VIS_END) && (y_next < V_VIS_END);
      frame_start <= wrap;
    end
  end

  // Register handshake state; update_req mirrors the next state so it rises together with (0, V_VISIBLE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      update_req <= 1'b0;
      miss_count <= '0;
    end else begin
      state      <= state_next;
      update_req <= (state_next == ST_REQ);
      miss_count <= miss_next;
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl using a shrunken timing set so many frames fit in a short run.
// A linear-position reference model predicts every output each clk; directed steps probe the corners.
module tb_vga_scan_ctrl;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] x_val;
  logic [9:0] y_val;
  logic       hsync;
  logic       vsync;
  logic       visible;
  logic       frame_start;
  logic       update_req;
  logic       update_ack;
  logic [7:0] miss_count;

  vga_scan_ctrl #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .x_val(x_val), .y_val(y_val), .hsync(hsync), .vsync(vsync),
    .visible(visible), .frame_start(frame_start),
    .update_req(update_req), .update_ack(update_ack), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: position is a single index into the frame.
  int m_pos  = 0;
  bit m_req  = 0;
  bit m_fs   = 0;
  int m_miss = 0;

  task automatic model_reset();
    m_pos = 0; m_req = 0; m_fs = 0; m_miss = 0;
  endtask

  task automatic model_step(input bit e, input bit a);
    bit was_req;
    was_req = m_req;
    m_fs = 0;
    if (was_req && a) m_req = 0;
    if (e) begin
      m_pos = m_pos + 1;
      if (m_pos == FT) begin
        m_pos = 0;
        m_fs  = 1;
        if (was_req && !a) begin
          m_req = 0;
          if (m_miss < 255) m_miss = m_miss + 1;
        end
      end
      if (m_pos == VV * HT) m_req = 1;
    end
  endtask

  function automatic logic [39:0] exp_vec();
    int x, y;
    logic hs, vs, vis;
    x   = m_pos % HT;
    y   = m_pos / HT;
    hs  = !(x >= HV + HF && x < HV + HF + HS);
    vs  = !(y >= VV + VF && y < VV + VF + VS);
    vis = (x < HV) && (y < VV);
    return {7'd0, 10'(x), 10'(y), hs, vs, vis, m_fs, m_req, 8'(m_miss)};
  endfunction

  function automatic logic [39:0] obs_vec();
    return {7'd0, x_val, y_val, hsync, vsync, visible, frame_start, update_req, miss_count};
  endfunction

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic tick(input logic e, input logic a);
    en = e;
    update_ack = a;
    @(posedge clk);
    model_step(e, a);
    #1;
    check("scan", obs_vec(), exp_vec());
  endtask

  initial begin
    int fs_cnt, fs_at, vis_low_x, hs_len, hs_start, vs_len, vs_start_y, vs_start_x, k;
    rst = 1'b1; en = 1'b0; update_ack = 1'b0;
    model_reset();
    #22;
    check("rst_x", 40'(x_val), 40'd0);
    check("rst_y", 40'(y_val), 40'd0);
    check("rst_hsync", 40'(hsync), 40'd1);
    check("rst_vsync", 40'(vsync), 40'd1);
    check("rst_visible", 40'(visible), 40'd1);
    check("rst_fs", 40'(frame_start), 40'd0);
    check("rst_req", 40'(update_req), 40'd0);
    check("rst_miss", 40'(miss_count), 40'd0);
    #6 rst = 1'b0;

    // One full frame with en held high.
    fs_cnt = 0; fs_at = -1; vis_low_x = -1; hs_len = 0; hs_start = -1;
    vs_len = 0; vs_start_y = -1; vs_start_x = -1;
    for (int i = 0; i < FT; i++) begin
      tick(1'b1, 1'b0);
      if (frame_start) begin fs_cnt++; fs_at = i + 1; end
      if (y_val == 0 && !visible && vis_low_x < 0) vis_low_x = int'(x_val);
      if (y_val == 0 && !hsync) begin
        hs_len++;
        if (hs_start < 0) hs_start = int'(x_val);
      end
      if (!vsync) begin
        vs_len++;
        if (vs_start_y < 0) begin vs_start_y = int'(y_val); vs_start_x = int'(x_val); end
      end
    end
    check("fs_count", 40'(fs_cnt), 40'd1);
    check("fs_at", 40'(fs_at), 40'(FT));
    check("wrap_xy", 40'({x_val, y_val}), 40'd0);
    check("vis_low_x", 40'(vis_low_x), 40'(HV));
    check("hs_len", 40'(hs_len), 40'(HS));
    check("hs_start", 40'(hs_start), 40'(HV + HF));
    check("vs_len", 40'(vs_len), 40'(VS * HT));
    check("vs_start_y", 40'(vs_start_y), 40'(VV + VF));
    check("vs_start_x", 40'(vs_start_x), 40'd0);

    // Two more unacked frames: three misses total.
    for (int i = 0; i < 2 * FT; i++) tick(1'b1, 1'b0);
    check("miss_3", 40'(miss_count), 40'd3);

    // Ack partway through the window.
    k = 0;
    while (!update_req && k < 2 * FT) begin tick(1'b1, 1'b0); k++; end
    check("req_rise", 40'(update_req), 40'd1);
    check("req_rise_xy", 40'({x_val, y_val}), 40'({10'd0, 10'(VV)}));
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check("req_fall", 40'(update_req), 40'd0);
    check("ack_miss", 40'(miss_count), 40'd3);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check("idle_ack_req", 40'(update_req), 40'd0);
    check("idle_ack_miss", 40'(miss_count), 40'd3);

    // Ack exactly on the wrapping edge of the next frame.
    k = 0;
    while (!(x_val == 10'(HT - 1) && y_val == 10'(VT - 1) && update_req) && k < 3 * FT) begin
      tick(1'b1, 1'b0); k++;
    end
    check("pre_wrap_req", 40'(update_req), 40'd1);
    tick(1'b1, 1'b1);
    check("wrap_ack_req", 40'(update_req), 40'd0);
    check("wrap_ack_xy", 40'({x_val, y_val}), 40'd0);
    check("wrap_ack_miss", 40'(miss_count), 40'd3);

    // en toggling each clk, starting low: frame_start to frame_start is 2*FT clk.
    k = 0;
    do begin
      tick(k % 2 == 1, 1'b0);
      k++;
    end while (!frame_start && k < 3 * FT);
    check("toggle_period", 40'(k), 40'(2 * FT));

    // Random en and sparse random ack against the model.
    for (int i = 0; i < 25 * FT; i++) tick($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);

    // Long unacked run: miss_count saturates without wrapping.
    for (int i = 0; i < 260 * FT; i++) tick(1'b1, 1'b0);
    check("miss_sat", 40'(miss_count), 40'd255);

    // Asynchronous reset in the middle of an open window.
    k = 0;
    while (!(x_val == 10'd3 && y_val == 10'(VV + 1)) && k < 2 * FT) begin tick(1'b1, 1'b0); k++; end
    check("pre_rst_req", 40'(update_req), 40'd1);
    #3 rst = 1'b1;
    #1;
    check("arst_x", 40'(x_val), 40'd0);
    check("arst_y", 40'(y_val), 40'd0);
    check("arst_sync", 40'({hsync, vsync, visible}), 40'd7);
    check("arst_fs", 40'(frame_start), 40'd0);
    check("arst_req", 40'(update_req), 40'd0);
    check("arst_miss", 40'(miss_count), 40'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold", obs_vec(), exp_vec());
    #2 rst = 1'b0;
    for (int i = 0; i < 2 * HT; i++) tick(1'b1, 1'b0);
    check("post_rst_miss", 40'(miss_count), 40'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Scan sequencer for the 640x480@60 Hz VGA output path. Generates the pixel position counters that feed the color stage, the active-low horizontal/vertical sync pulses, a visible-area flag and a frame-start strobe. Also runs a per-frame update handshake with the game logic, so game state changes only during vertical blanking, and counts frames where the game logic missed that window.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch (line total 800)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch (frame total 525)

Ports:
- clk  in  1  VGA clock (25 MHz)
- rst  in  1  reset, asynchronous, active-high
- en  in  1  pixel advance enable; counters step only on clk edges with en=1
- x_val  out  10  current column, 0..799
- y_val  out  10  current line, 0..524
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- visible  out  1  1 when x_val<640 and y_val<480
- frame_start  out  1  one-clk pulse on entry to (0,0)
- update_req  out  1  game-update window request, level
- update_ack  in  1  game logic has finished its frame update
- miss_count  out  8  frames whose update window closed without ack, saturating

## Operation
- All outputs are registered. hsync, vsync and visible are decoded from the next counter value, so they always match the x_val/y_val presented in the same cycle.
- Counting (en=1): x_val increments. When x_val=799, x_val goes to 0 and y_val increments. When x_val=799 and y_val=524, both go to 0 (wrap).
- en=0: counters, hsync, vsync, visible and update_req hold. Pulses still end after one clk.
- hsync=0 for x_val in 656..751. vsync=0 for y_val in 490..491. All sync bounds derive from the parameters.
- frame_start=1 for exactly one clk after the en-qualified edge that wraps to (0,0). It does not pulse on reset release.
- Update handshake, two states:
  - IDLE: update_req=0. The en-qualified edge that moves the counters to (0,480) enters REQ; update_req=1 in that same cycle.
  - REQ: update_req=1.
    - Any cycle with update_ack=1 returns to IDLE; update_req=0 on the next cycle.
    - If the counters wrap to (0,0) without an ack, return to IDLE and increment miss_count, saturating at 255.
    - If ack and the wrapping edge coincide, it counts as acked: no increment.
- update_ack in IDLE is ignored.
- miss_count clears only on reset.

## Timing
- Reset values: x_val=0, y_val=0, hsync=1, vsync=1, visible=1, frame_start=0, update_req=0, miss_count=0, state IDLE.
- Reset mid-frame returns everything to the reset values immediately. An open update window is dropped without counting a miss.
- Latency: hsync, vsync and visible have zero cycles of skew relative to x_val/y_val. frame_start and update_req are coincident with their counter position.
- With en=1 continuously, one line is 800 clk and one frame is 420000 clk. frame_start period is 420000 clk.
- update_req rises at (0,480) and is high for at most 45×800=36000 en-steps. The game logic may ack on any clk while it is high, including the first.
- Ack latency: update_req falls on the clk after update_ack is sampled high, independent of en.

## Test plan
- Reset release, en=1 for 420000 clk:
  - x_val/y_val step 0..799/0..524 and return to (0,0).
  - frame_start pulses once, at clk 420000.
  - visible goes low at x_val=640.
- Sync windows:
  - hsync low for exactly 96 clk, starting at x_val=656.
  - vsync low for exactly 1600 clk, starting at (0,490).
- Ack handshake: ack 100 clk after update_req rises.
  - update_req falls the next clk.
  - miss_count stays 0.
  - A second ack pulse while update_req=0 has no effect.
- No ack for 3 frames, then 300 frames with no ack:
  - miss_count=3 after the first 3 frames.
  - miss_count saturates at 255 and does not wrap.
- Ack asserted on the exact wrapping edge from (799,524): no miss counted, update_req=0 at (0,0).
- Controls:
  - en toggled 1/0 every clk: counters advance every other clk and a frame takes 840000 clk.
  - rst asserted at (300,485) with update_req high: all outputs return to reset values asynchronously and miss_count stays at its pre-reset-cleared value of 0.
